// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - MSP430 format I two-operand fetch sequencer
module operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  src_reg,
    input  logic [3:0]  dst_reg,
    input  logic [1:0]  As,
    input  logic        Ad,
    input  logic        BW,
    output logic [3:0]  reg_SA,
    output logic [3:0]  reg_DA,
    output logic [1:0]  As_out,
    input  logic [15:0] Sout,
    input  logic [15:0] Dout,
    input  logic [15:0] pc_in,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        pc_inc,
    output logic        wb_req,
    output logic [3:0]  wb_reg,
    output logic [15:0] wb_data,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [15:0] src_op,
    output logic [15:0] dst_op,
    output logic [15:0] dst_addr,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, SRC_EXT, SRC_MEM, DST_EXT, DST_MEM, OUT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  src_q, src_d, dst_q, dst_d;
    logic [1:0]  as_q, as_d;
    logic        ad_q, ad_d, bw_q, bw_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] src_op_q, src_op_d, dst_op_q, dst_op_d, dst_addr_q, dst_addr_d;
    logic        pc_inc_q, pc_inc_d;
    logic        accept, src_done, ad_now, autoinc;
    logic [15:0] ext_addr;

    // Byte operations take the addressed half of the word, zero-extended.
    function automatic logic [15:0] byte_sel(input logic [15:0] d, input logic bw, input logic hi);
        if (!bw) return d;
        return hi ? {8'h00, d[15:8]} : {8'h00, d[7:0]};
    endfunction

    // In the start cycle the register file must already see the new fields.
    assign accept   = (state_q == IDLE) && start;
    assign reg_SA   = accept ? src_reg : src_q;
    assign reg_DA   = accept ? dst_reg : dst_q;
    assign As_out   = accept ? As : as_q;
    // While pc_inc is pulsing the register file still shows the old PC;
    // anticipate the increment so an extension-word address never moves.
    assign ext_addr = pc_in + (pc_inc_q ? 16'd2 : 16'd0);
    assign autoinc  = (as_q == 2'b11) && (src_q != 4'd0) && (src_q != 4'd2) && (src_q != 4'd3);

    assign busy     = (state_q != IDLE);
    assign op_valid = (state_q == OUT);
    assign pc_inc   = pc_inc_q;
    assign src_op   = src_op_q;
    assign dst_op   = dst_op_q;
    assign dst_addr = dst_addr_q;

    // Next-state, memory requests and write-back pulses for each fetch phase.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        as_d       = as_q;
        ad_d       = ad_q;
        bw_d       = bw_q;
        addr_d     = addr_q;
        src_op_d   = src_op_q;
        dst_op_d   = dst_op_q;
        dst_addr_d = dst_addr_q;
        pc_inc_d   = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = 16'h0000;
        wb_req     = 1'b0;
        wb_reg     = 4'h0;
        wb_data    = 16'h0000;
        src_done   = 1'b0;
        ad_now     = ad_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d  = src_reg;
                    dst_d  = dst_reg;
                    as_d   = As;
                    ad_d   = Ad;
                    bw_d   = BW;
                    ad_now = Ad;
                    if (src_reg == 4'd3 || (src_reg == 4'd2 && As[1]) || As == 2'b00) begin
                        src_op_d = Sout;
                        src_done = 1'b1;
                    end else if (As == 2'b01 || (src_reg == 4'd0 && As == 2'b11)) begin
                        state_d = SRC_EXT;
                    end else begin
                        addr_d  = Sout;
                        state_d = SRC_MEM;
                    end
                end
            end
            SRC_EXT: begin
                mem_rd   = 1'b1;
                mem_addr = ext_addr;
                if (mem_ack) begin
                    pc_inc_d = 1'b1;
                    if (as_q == 2'b11) begin
                        src_op_d = byte_sel(mem_data, bw_q, ext_addr[0]);
                        src_done = 1'b1;
                    end else begin
                        addr_d  = mem_data + ((src_q == 4'd2) ? 16'h0000 : Sout);
                        state_d = SRC_MEM;
                    end
                end
            end
            SRC_MEM: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    src_op_d = byte_sel(mem_data, bw_q, addr_q[0]);
                    src_done = 1'b1;
                    if (autoinc) begin
                        wb_req  = 1'b1;
                        wb_reg  = src_q;
                        wb_data = Sout + ((bw_q && (src_q >= 4'd4)) ? 16'd1 : 16'd2);
                    end
                end
            end
            DST_EXT: begin
                mem_rd   = 1'b1;
                mem_addr = ext_addr;
                if (mem_ack) begin
                    pc_inc_d = 1'b1;
                    addr_d   = mem_data + ((dst_q == 4'd2) ? 16'h0000 : Dout);
                    state_d  = DST_MEM;
                end
            end
            DST_MEM: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) begin
                    dst_op_d   = byte_sel(mem_data, bw_q, addr_q[0]);
                    dst_addr_d = addr_q;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (op_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (src_done) begin
            if (ad_now) begin
                state_d = DST_EXT;
            end else begin
                dst_op_d   = Dout;
                dst_addr_d = 16'h0000;
                state_d    = OUT;
            end
        end
    end

    // State and datapath registers; reset abandons any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= 4'h0;
            dst_q      <= 4'h0;
            as_q       <= 2'b00;
            ad_q       <= 1'b0;
            bw_q       <= 1'b0;
            addr_q     <= 16'h0000;
            src_op_q   <= 16'h0000;
            dst_op_q   <= 16'h0000;
            dst_addr_q <= 16'h0000;
            pc_inc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            as_q       <= as_d;
            ad_q       <= ad_d;
            bw_q       <= bw_d;
            addr_q     <= addr_d;
            src_op_q   <= src_op_d;
            dst_op_q   <= dst_op_d;
            dst_addr_q <= dst_addr_d;
            pc_inc_q   <= pc_inc_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed vector bench for operand_fetch
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  src_reg = 4'h0, dst_reg = 4'h0;
    logic [1:0]  As = 2'b00;
    logic        Ad = 1'b0, BW = 1'b0;
    logic [3:0]  reg_SA, reg_DA;
    logic [1:0]  As_out;
    logic [15:0] Sout = 16'h0, Dout = 16'h0, pc_in = 16'h0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic        pc_inc, wb_req;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        op_valid;
    logic        op_ready = 1'b1;
    logic [15:0] src_op, dst_op, dst_addr;
    logic        busy;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst), .start(start), .src_reg(src_reg), .dst_reg(dst_reg),
        .As(As), .Ad(Ad), .BW(BW), .reg_SA(reg_SA), .reg_DA(reg_DA), .As_out(As_out),
        .Sout(Sout), .Dout(Dout), .pc_in(pc_in), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .pc_inc(pc_inc), .wb_req(wb_req),
        .wb_reg(wb_reg), .wb_data(wb_data), .op_valid(op_valid), .op_ready(op_ready),
        .src_op(src_op), .dst_op(dst_op), .dst_addr(dst_addr), .busy(busy)
    );

    int checks = 0, failures = 0;
    int n_pcinc = 0, n_wb = 0, n_reads = 0, n_clash = 0, n_unstable = 0, n_rd_drop = 0;
    logic [15:0] last_wb_data = 16'h0;
    logic [3:0]  last_wb_reg = 4'h0;
    int wait_cycles = 0, rd_cnt = 0, lat;
    bit mem_en = 1'b1, rd_active = 1'b0, pc_pend = 1'b0;
    logic [15:0] rd_addr = 16'h0;
    logic [15:0] mem [logic [15:0]];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] k;
        k = {a[15:1], 1'b0};
        return mem.exists(k) ? mem[k] : 16'hDEAD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Observe pulses and read stability mid-cycle.
    initial forever begin
        @(negedge clk);
        if (pc_inc) begin n_pcinc++; pc_pend = 1'b1; end
        if (wb_req) begin n_wb++; last_wb_data = wb_data; last_wb_reg = wb_reg; end
        if (pc_inc && wb_req) n_clash++;
        if (mem_rd && mem_ack) n_reads++;
        if (rd_active && !mem_rd) n_rd_drop++;
        if (rd_active && mem_rd && mem_addr !== rd_addr) n_unstable++;
        rd_active = mem_rd && !mem_ack;
        rd_addr   = mem_addr;
    end

    // Register-file PC model and memory responder, updated just after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (pc_pend) begin pc_in = pc_in + 16'd2; pc_pend = 1'b0; end
        if (mem_en) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                rd_cnt  = mem_rd ? 1 : 0;
            end else if (mem_rd) begin
                rd_cnt++;
                if (rd_cnt >= wait_cycles + 2) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_word(mem_addr);
                end
            end else begin
                rd_cnt = 0;
            end
        end else begin
            rd_cnt = 0;
        end
    end

    task automatic run_op(input logic [3:0] s, input logic [3:0] d, input logic [1:0] m,
                          input logic a, input logic b, output int l);
        n_pcinc = 0; n_wb = 0; n_reads = 0;
        src_reg = s; dst_reg = d; As = m; Ad = a; BW = b; start = 1'b1;
        l = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            l++;
        end while (!op_valid && l < 200);
    endtask

    typedef struct {
        logic [3:0]  s, d;
        logic [1:0]  as_m;
        logic        ad, bw;
        logic [15:0] sout, dout, pc;
        logic [15:0] e_src, e_dst, e_daddr, e_wbdata;
        int          e_lat, e_pcinc, e_wb, e_reads;
    } vec_t;

    vec_t vt[14];

    initial begin
        mem[16'hC000] = 16'h0010; mem[16'hC002] = 16'h0300; mem[16'h0210] = 16'h5555;
        mem[16'h0300] = 16'h7788; mem[16'h0200] = 16'hABCD; mem[16'h0110] = 16'hBEEF;
        mem[16'h0008] = 16'h1111; mem[16'h0010] = 16'h2222;

        //          s     d     As     Ad    BW    Sout      Dout      pc        src       dst       daddr     wbdata   lat pc wb rd
        vt[0]  = '{4'd5, 4'd7, 2'b00, 1'b0, 1'b0, 16'h1234, 16'h00FF, 16'hC000, 16'h1234, 16'h00FF, 16'h0000, 16'h0000, 1, 0, 0, 0};
        vt[1]  = '{4'd3, 4'd7, 2'b11, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hC000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0};
        vt[2]  = '{4'd2, 4'd7, 2'b10, 1'b0, 1'b0, 16'h0004, 16'h0055, 16'hC000, 16'h0004, 16'h0055, 16'h0000, 16'h0000, 1, 0, 0, 0};
        vt[3]  = '{4'd4, 4'd7, 2'b10, 1'b0, 1'b0, 16'h0200, 16'h0011, 16'hC000, 16'hABCD, 16'h0011, 16'h0000, 16'h0000, 3, 0, 0, 1};
        vt[4]  = '{4'd4, 4'd2, 2'b01, 1'b1, 1'b0, 16'h0200, 16'h9999, 16'hC000, 16'h5555, 16'h7788, 16'h0300, 16'h0000, 9, 2, 0, 4};
        vt[5]  = '{4'd0, 4'd7, 2'b11, 1'b0, 1'b0, 16'hC000, 16'h0022, 16'hC000, 16'h0010, 16'h0022, 16'h0000, 16'h0000, 3, 1, 0, 1};
        vt[6]  = '{4'd6, 4'd7, 2'b11, 1'b0, 1'b1, 16'h0201, 16'h0033, 16'hC000, 16'h00AB, 16'h0033, 16'h0000, 16'h0202, 3, 0, 1, 1};
        vt[7]  = '{4'd1, 4'd7, 2'b11, 1'b0, 1'b1, 16'h0201, 16'h0033, 16'hC000, 16'h00AB, 16'h0033, 16'h0000, 16'h0203, 3, 0, 1, 1};
        vt[8]  = '{4'd5, 4'd7, 2'b11, 1'b0, 1'b0, 16'h0200, 16'h0044, 16'hC000, 16'hABCD, 16'h0044, 16'h0000, 16'h0202, 3, 0, 1, 1};
        vt[9]  = '{4'd4, 4'd7, 2'b10, 1'b0, 1'b1, 16'h0200, 16'h0000, 16'hC000, 16'h00CD, 16'h0000, 16'h0000, 16'h0000, 3, 0, 0, 1};
        vt[10] = '{4'd4, 4'd5, 2'b00, 1'b1, 1'b0, 16'h0300, 16'hFFF8, 16'hC000, 16'h0300, 16'h1111, 16'h0008, 16'h0000, 5, 1, 0, 2};
        vt[11] = '{4'd2, 4'd7, 2'b01, 1'b0, 1'b0, 16'h1234, 16'h0066, 16'hC000, 16'h2222, 16'h0066, 16'h0000, 16'h0000, 5, 1, 0, 2};
        vt[12] = '{4'd3, 4'd7, 2'b01, 1'b0, 1'b0, 16'h0001, 16'h0077, 16'hC000, 16'h0001, 16'h0077, 16'h0000, 16'h0000, 1, 0, 0, 0};
        vt[13] = '{4'd4, 4'd4, 2'b00, 1'b1, 1'b1, 16'h0005, 16'h0100, 16'hC000, 16'h0005, 16'h00EF, 16'h0110, 16'h0000, 5, 1, 0, 2};

        repeat (2) @(negedge clk);
        chk("reset_ctl", {busy, op_valid, mem_rd, pc_inc, wb_req, reg_SA, reg_DA, As_out, wb_reg}, 32'h0);
        chk("reset_addr", {mem_addr, wb_data}, 32'h0);
        chk("reset_ops", {src_op, dst_op}, 32'h0);
        chk("reset_daddr", {16'h0, dst_addr}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            Sout = vt[i].sout; Dout = vt[i].dout; pc_in = vt[i].pc;
            run_op(vt[i].s, vt[i].d, vt[i].as_m, vt[i].ad, vt[i].bw, lat);
            chk($sformatf("v%0d_latency", i), lat, vt[i].e_lat);
            chk($sformatf("v%0d_src_op", i), {16'h0, src_op}, {16'h0, vt[i].e_src});
            chk($sformatf("v%0d_dst_op", i), {16'h0, dst_op}, {16'h0, vt[i].e_dst});
            chk($sformatf("v%0d_dst_addr", i), {16'h0, dst_addr}, {16'h0, vt[i].e_daddr});
            chk($sformatf("v%0d_pc_inc_count", i), n_pcinc, vt[i].e_pcinc);
            chk($sformatf("v%0d_wb_count", i), n_wb, vt[i].e_wb);
            chk($sformatf("v%0d_read_count", i), n_reads, vt[i].e_reads);
            if (vt[i].e_wb != 0) begin
                chk($sformatf("v%0d_wb_data", i), {16'h0, last_wb_data}, {16'h0, vt[i].e_wbdata});
                chk($sformatf("v%0d_wb_reg", i), {28'h0, last_wb_reg}, {28'h0, vt[i].s});
            end
            @(negedge clk);
            chk($sformatf("v%0d_busy_after", i), {31'h0, busy}, 32'h0);
            chk($sformatf("v%0d_pc_final", i), {16'h0, pc_in}, {16'h0, vt[i].pc + 16'(2 * vt[i].e_pcinc)});
        end

        // Wait states on an indirect read, then execute-stage backpressure.
        wait_cycles = 3; op_ready = 1'b0;
        Sout = 16'h0200; Dout = 16'h0012; pc_in = 16'hC000;
        run_op(4'd4, 4'd7, 2'b10, 1'b0, 1'b0, lat);
        chk("ws_latency", lat, 6);
        chk("ws_reads", n_reads, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_valid_%0d", k), {31'h0, op_valid}, 32'h1);
            chk($sformatf("bp_hold_ops_%0d", k), {src_op, dst_op}, {16'hABCD, 16'h0012});
        end
        op_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_busy", {31'h0, busy}, 32'h0);
        chk("addr_stable", n_unstable, 0);
        chk("rd_held_to_ack", n_rd_drop, 0);

        // start while busy, and start in the OUT completion cycle, are ignored.
        wait_cycles = 2;
        src_reg = 4'd4; dst_reg = 4'd7; As = 2'b10; Ad = 1'b0; BW = 1'b0; start = 1'b1;
        @(negedge clk);
        src_reg = 4'd3; dst_reg = 4'd9; As = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("guard_latched_fields", {24'h0, reg_SA, reg_DA}, {24'h0, 4'd4, 4'd7});
        chk("guard_latched_as", {30'h0, As_out}, {30'h0, 2'b10});
        lat = 0;
        while (!op_valid && lat < 50) begin @(negedge clk); lat++; end
        chk("guard_done_valid", {31'h0, op_valid}, 32'h1);
        chk("guard_src_op", {16'h0, src_op}, {16'h0, 16'hABCD});
        src_reg = 4'd5; As = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_out_ignored", {30'h0, busy, op_valid}, 32'h0);
        @(negedge clk);
        chk("start_at_out_still_idle", {31'h0, busy}, 32'h0);
        wait_cycles = 0;

        // Asynchronous reset in the middle of a source read.
        mem_en = 1'b0; mem_ack = 1'b0;
        Sout = 16'h0200;
        src_reg = 4'd4; dst_reg = 4'd7; As = 2'b10; Ad = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_pre_mem_rd", {31'h0, mem_rd}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mem_rd_drop", {31'h0, mem_rd}, 32'h0);
        chk("rst_busy_drop", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_data = 16'h5A5A;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_ignored", {29'h0, busy, op_valid, wb_req}, 32'h0);
        chk("late_ack_src_op", {16'h0, src_op}, 32'h0);
        @(negedge clk);
        chk("late_ack_idle", {31'h0, busy}, 32'h0);
        mem_en = 1'b1;

        chk("no_pc_inc_wb_clash", n_clash, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Two-operand (format I) operand fetch sequencer for the MSP430 core. It takes decoded instruction fields and drives the register file's read ports (source/destination address and As mode), then collects the register outputs Sout/Dout and the PC. It performs the extension-word and data-memory reads the addressing mode needs, and presents resolved source and destination operands to the execute stage over a valid/ready handshake. It also issues autoincrement write-back requests and PC-advance pulses, and never writes the register file directly.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  decoded fields valid; accepted only in IDLE
- src_reg, dst_reg  in  4  source / destination register number
- As  in  2  source addressing mode
- Ad  in  1  destination mode: 0 register, 1 indexed
- BW  in  1  1 = byte operation
- reg_SA, reg_DA  out  4  register file read addresses
- As_out  out  2  mode to register file (drives constant generators)
- Sout, Dout, pc_in  in  16  register file source, destination and PC outputs
- mem_rd  out  1  memory read request
- mem_addr  out  16  read address
- mem_ack  in  1  read complete; mem_data valid this cycle
- mem_data  in  16  read data
- pc_inc  out  1  one-cycle pulse: PC += 2
- wb_req  out  1  one-cycle pulse: write wb_data to wb_reg
- wb_reg  out  4  write-back register
- wb_data  out  16  write-back value
- op_valid  out  1  operands valid
- op_ready  in  1  execute stage accepts
- src_op, dst_op, dst_addr  out  16  source value, destination value, destination memory address (0 in register mode)
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, SRC_EXT, SRC_MEM, DST_EXT, DST_MEM, OUT.
- On start in IDLE, the fields are latched, and reg_SA/reg_DA/As_out are driven from the latched values until return to IDLE.
- Source classification, evaluated in the start cycle:
  - Constant: src_reg=3 (any As), or src_reg=2 with As=10/11. src_op = Sout, no memory access.
  - Register: As=00. src_op = Sout.
  - Immediate: src_reg=0, As=11. Go to SRC_EXT; src_op = mem_data; pulse pc_inc.
  - Indexed: As=01. Go to SRC_EXT, read the word at pc_in, pulse pc_inc, then go to SRC_MEM at address ext+Sout. Absolute mode (src_reg=2) uses base 0.
  - Indirect: As=10, or As=11 with src_reg≠0. Go to SRC_MEM at Sout.
- Autoincrement (As=11, src_reg≠0/2/3): on the SRC_MEM ack cycle, pulse wb_req with wb_reg=src_reg and wb_data=Sout+inc. inc=1 if BW=1 and src_reg≥4; otherwise inc=2.
- Byte reads: the byte is selected by mem_addr[0] (1 = high byte) and zero-extended.
- Destination, evaluated after the source is done:
  - Ad=0: dst_op = Dout, dst_addr=0.
  - Ad=1: DST_EXT reads the word at pc_in and pulses pc_inc; DST_MEM reads address ext+Dout (base 0 if dst_reg=2); dst_addr = that address and dst_op = the byte-selected read data.
- OUT: op_valid held high until op_ready, then return to IDLE.
- Address arithmetic is 16-bit modulo; ext+base wraps with no flag.

## Timing
- Reset values: all outputs 0, state IDLE. Async rst mid-read drops mem_rd immediately and abandons the access; a later mem_ack is ignored.
- Memory handshake: mem_rd and mem_addr are stable from request until the cycle mem_ack=1. mem_data is captured in that cycle, and mem_rd falls the next cycle unless a new read follows.
- pc_in is sampled on the mem_ack cycle of each EXT read. The pc_inc pulse is emitted in the cycle after that ack, so the next EXT read sees the updated PC.
- Latency from start to op_valid, with a zero-wait memory (ack the cycle after rd):
  - Register/constant source, Ad=0: 1 cycle.
  - Each memory read adds 2 cycles.
- op_valid with op_ready already high completes in that cycle; busy falls in the next cycle.
- start while busy is ignored. start in the same cycle as OUT completion is also ignored.
- wb_req and pc_inc never occur in the same cycle.

## Test plan
- Register mode: src_reg=5, As=00, Sout=1234h, Dout=00FFh, Ad=0 → op_valid 1 cycle later with src_op=1234h, dst_op=00FFh, no mem_rd.
- Constant generator: src_reg=3, As=11 (Sout=FFFFh) → src_op=FFFFh, no mem_rd and no pc_inc.
- Indexed source with absolute destination: pc_in=C000h, ext=0010h, Sout=0200h, Ad=1, dst_reg=2:
  - Source reads C000h then 0210h.
  - Destination reads the word at the updated PC, C002h (ext 0300h), then address 0300h.
  - Two pc_inc pulses; dst_addr=0300h.
- Autoincrement byte: src_reg=6, As=11, BW=1, Sout=0201h, mem_data=ABCDh → src_op=00ABh; wb_req with wb_reg=6, wb_data=0202h. Repeat with src_reg=1 → wb_data=0203h.
- Wait states and backpressure: mem_ack delayed 3 cycles → mem_rd and mem_addr held stable throughout. op_ready low for 4 cycles → op_valid and operands held.
- Reset and start guards:
  - Assert rst during SRC_MEM → mem_rd=0 in the same cycle, state IDLE; a late mem_ack is ignored.
  - start while busy → ignored.
